// File: rtl/sum_series_inverse.sv
// Inverse triangular-number search: finds the largest N with 1+2+...+N <= S by
// subtracting successive integers from S, leaving the remainder S - N(N+1)/2.
// One subtraction per clock, so a result for N takes N+1 loop cycles.
module sum_series_inverse #(
    parameter int unsigned W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [W-1:0] Data_in,
    output logic [W-1:0] N_out,
    output logic [W-1:0] Rem_out,
    output logic         Exact,
    output logic         Busy,
    output logic         Stop
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSub  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   r_q, r_d;     // running remainder
    logic [W-1:0]   c_q, c_d;     // next term to subtract
    logic [W-1:0]   n_q, n_d;     // terms subtracted so far

    // State and datapath registers; Reset clears everything without waiting for Clk.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            r_q     <= '0;
            c_q     <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            n_q     <= n_d;
        end
    end

    // Next-state and datapath update: capture in IDLE, subtract while R >= C, hold in DONE.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        n_d     = n_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    r_d     = Data_in;
                    c_d     = W'(1);
                    n_d     = '0;
                    state_d = StSub;
                end
            end
            StSub: begin
                // Start and Data_in are deliberately ignored here.
                if (r_q >= c_q) begin
                    r_d = r_q - c_q;
                    n_d = n_q + W'(1);
                    c_d = c_q + W'(1);
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Result holds while Start stays high; a new run needs Start low first.
                if (!Start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode directly from state and registers.
    always_comb begin
        Busy    = (state_q == StSub);
        Stop    = (state_q == StDone);
        N_out   = n_q;
        Rem_out = r_q;
        Exact   = (state_q == StDone) && (r_q == '0);
    end

    // The loop exits as soon as R < C = N+1, so a finished remainder never exceeds N.
    a_rem_bounded: assert property (@(posedge Clk) disable iff (Reset)
        (state_q == StDone) |-> (r_q <= n_q));

    // The term counter always runs one ahead of the count while looping.
    a_term_tracks_count: assert property (@(posedge Clk) disable iff (Reset)
        (state_q == StSub) |-> (c_q == n_q + W'(1)));

endmodule

// File: tb/tb_sum_series_inverse.sv
// Self-checking bench for sum_series_inverse: directed boundary vectors, randomized
// conversions against a closed-form triangular-number model, reset and handshake cases.
module tb_sum_series_inverse;

    localparam int W = 8;

    logic         Clk;
    logic         Reset;
    logic         Start;
    logic [W-1:0] Data_in;
    logic [W-1:0] N_out;
    logic [W-1:0] Rem_out;
    logic         Exact;
    logic         Busy;
    logic         Stop;

    int n_checks = 0;
    int n_fail   = 0;

    sum_series_inverse #(.W(W)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Data_in (Data_in),
        .N_out   (N_out),
        .Rem_out (Rem_out),
        .Exact   (Exact),
        .Busy    (Busy),
        .Stop    (Stop)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: largest n with n(n+1)/2 <= s, remainder, and the expected latency n+1.
    function automatic void model(input int s, output int n, output int rem, output int lat);
        n = 0;
        while ((n + 1) * (n + 2) / 2 <= s) n++;
        rem = s - n * (n + 1) / 2;
        lat = n + 1;
    endfunction

    // Present Start/Data_in at a falling edge and return just after the capture edge.
    task automatic capture(input logic [W-1:0] s);
        @(negedge Clk);
        Start   = 1'b1;
        Data_in = s;
        @(posedge Clk);
        #1;
    endtask

    // Counts edges until Stop rises (-1 on timeout); flags any bad in-flight outputs.
    // With scramble set, Start and Data_in are randomized while the loop runs.
    task automatic wait_stop(input logic scramble, output int lat, output logic mid_ok);
        lat    = -1;
        mid_ok = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge Clk);
            #1;
            if (Stop) begin
                lat = k;
                break;
            end
            if (!Busy || Exact) mid_ok = 1'b0;
            if (scramble) begin
                Data_in = W'($urandom);
                Start   = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic release_start();
        Start = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset   = 1'b1;
        Start   = 1'b1;
        Data_in = 8'd77;
        #2;
        n_checks++;
        if ({N_out, Rem_out, Exact, Busy, Stop} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got N=%0d R=%0d E=%b B=%b S=%b, need all 0",
                     N_out, Rem_out, Exact, Busy, Stop);
        end
        repeat (3) @(posedge Clk);
        #1;
        n_checks++;
        if (Busy !== 1'b0 || Stop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: got B=%b S=%b while Reset=1 with Start=1, need 0 0",
                     Busy, Stop);
        end
        @(negedge Clk);
        Start = 1'b0;
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if (Busy !== 1'b0 || Stop !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_wait: got B=%b S=%b with Start=0 after reset, need 0 0",
                     Busy, Stop);
        end
    endtask

    task automatic run_vector(input int s, input logic scramble, input string tag);
        int   n, rem, lat_exp, lat;
        logic mid_ok;
        model(s, n, rem, lat_exp);
        capture(W'(s));
        n_checks++;
        if (Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy S=%0d: got Busy=%b after capture, need 1", tag, s, Busy);
        end
        wait_stop(scramble, lat, mid_ok);
        n_checks++;
        if (lat != lat_exp) begin
            n_fail++;
            $display("FAIL %s_latency S=%0d: got %0d edges, need %0d", tag, s, lat, lat_exp);
        end
        n_checks++;
        if (!mid_ok) begin
            n_fail++;
            $display("FAIL %s_inflight S=%0d: got Busy=0 or Exact=1 before Stop, need 1/0",
                     tag, s);
        end
        n_checks++;
        if (N_out !== W'(n) || Rem_out !== W'(rem) || Exact !== (rem == 0)) begin
            n_fail++;
            $display("FAIL %s_result S=%0d: got N=%0d R=%0d E=%b, need N=%0d R=%0d E=%b",
                     tag, s, N_out, Rem_out, Exact, n, rem, rem == 0);
        end
        release_start();
        n_checks++;
        if (Stop !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release S=%0d: got Stop=%b after Start low, need 0", tag, s, Stop);
        end
    endtask

    task automatic test_directed();
        int vec [6] = '{10, 45, 78, 20, 0, 255};
        foreach (vec[i]) run_vector(vec[i], 1'b0, "directed");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) run_vector(int'($urandom_range(0, 255)), 1'b1, "random");
    endtask

    task automatic test_reset_mid_sub();
        capture(8'd36);
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        n_checks++;
        if ({N_out, Rem_out, Exact, Busy, Stop} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got N=%0d R=%0d E=%b B=%b S=%b, need all 0",
                     N_out, Rem_out, Exact, Busy, Stop);
        end
        @(negedge Clk);
        Start = 1'b0;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        n_checks++;
        if (Busy !== 1'b0 || Stop !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got B=%b S=%b after abort, need 0 0", Busy, Stop);
        end
        run_vector(28, 1'b0, "restart");
    endtask

    task automatic test_done_hold();
        int   lat;
        logic mid_ok;
        capture(8'd10);
        wait_stop(1'b0, lat, mid_ok);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            Data_in = W'($urandom);
            @(posedge Clk);
            #1;
            n_checks++;
            if (Stop !== 1'b1 || N_out !== 8'd4 || Rem_out !== 8'd0 || Exact !== 1'b1) begin
                n_fail++;
                $display("FAIL done_hold: got S=%b N=%0d R=%0d E=%b, need S=1 N=4 R=0 E=1",
                         Stop, N_out, Rem_out, Exact);
            end
        end
        release_start();
        n_checks++;
        if (Stop !== 1'b0 || Exact !== 1'b0) begin
            n_fail++;
            $display("FAIL done_exit: got Stop=%b Exact=%b, need 0 0", Stop, Exact);
        end
        run_vector(6, 1'b0, "after_done");
    endtask

    task automatic test_start_at_release();
        @(negedge Clk);
        Reset   = 1'b1;
        Start   = 1'b1;
        Data_in = 8'd15;
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        n_checks++;
        if (Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL release_capture: got Busy=%b on first edge after reset, need 1", Busy);
        end
        begin
            int   lat;
            logic mid_ok;
            wait_stop(1'b0, lat, mid_ok);
            n_checks++;
            if (lat != 6 || N_out !== 8'd5 || Rem_out !== 8'd0 || Exact !== 1'b1) begin
                n_fail++;
                $display("FAIL release_result: got lat=%0d N=%0d R=%0d E=%b, need 6 5 0 1",
                         lat, N_out, Rem_out, Exact);
            end
        end
        release_start();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_sub();
        test_done_hold();
        test_start_at_release();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_series_inverse.md
SUM_SERIES_INVERSE -- requirements
Module: sum_series_inverse

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the width of Data_in, N_out and Rem_out.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port Start, input, 1 bit: level request to begin a conversion.
REQ-005 The block SHALL have port Data_in, input, W bits: unsigned target sum S, captured on the start edge.
REQ-006 The block SHALL have port N_out, output, W bits: largest N with 1+2+...+N <= S.
REQ-007 The block SHALL have port Rem_out, output, W bits: S minus N(N+1)/2.
REQ-008 The block SHALL have port Exact, output, 1 bit: high when S is exactly triangular (Rem_out == 0).
REQ-009 The block SHALL have port Busy, output, 1 bit: high while the subtraction loop runs.
REQ-010 The block SHALL have port Stop, output, 1 bit: high when the result is valid.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, SUB, DONE.
REQ-012 Internal registers SHALL be R (W bits, remainder), C (W bits, next term) and N (W bits, count).
REQ-013 In IDLE with Start=1 at a rising edge: R<=Data_in, C<=1, N<=0, and the FSM goes to SUB; Start=0 keeps the FSM in IDLE.
REQ-014 In SUB, each edge with R >= C: R<=R-C, N<=N+1, C<=C+1, and the FSM stays in SUB.
REQ-015 In SUB, the edge with R < C: the FSM goes to DONE, and R and N hold.
REQ-016 Start and Data_in SHALL be ignored while in SUB.
REQ-017 In DONE, R, N and outputs SHALL hold while Start=1; on an edge with Start=0, the FSM returns to IDLE.
REQ-018 A new conversion SHALL require Start low then high again, i.e. passing through IDLE.
REQ-019 Latency: Stop SHALL rise exactly N+1 edges after the capture edge; the total number of SUB-state edges is N+1.
REQ-020 Outputs SHALL be: Busy = (state==SUB); Stop = (state==DONE); N_out = N; Rem_out = R; Exact = Stop AND (R==0).
REQ-021 Exact SHALL be 0 whenever Stop=0.
REQ-022 N_out and Rem_out SHALL be compared only while Stop=1; they may change during SUB.
REQ-023 All arithmetic SHALL be unsigned W-bit.
REQ-024 Subtraction SHALL only occur when R >= C, so R never underflows.
REQ-025 C never exceeds N+1, so C does not overflow for any S < 2^W.
REQ-026 Boundary S=0: the first SUB edge sees 0<1, so the result is N=0, Rem=0, Exact=1, with Stop 1 edge after capture.
REQ-027 Boundary S=2^W-1 (255 for W=8): the result is N=22, Rem=2, Exact=0.
REQ-028 Remainder SHALL always satisfy 0 <= Rem_out <= N_out.

Reset
REQ-029 Reset=1 SHALL immediately, without waiting for Clk, force state IDLE and R=C=N=0.
REQ-030 While Reset=1, outputs SHALL be N_out=0, Rem_out=0, Exact=0, Busy=0, Stop=0.
REQ-031 Reset asserted mid-SUB or in DONE SHALL abort the conversion; no partial result is retained.
REQ-032 After Reset deasserts, the block SHALL wait in IDLE for Start=1.
REQ-033 If Start is already high when Reset deasserts, capture SHALL occur on the first subsequent rising edge.

Verification
REQ-034 Scenario: Start=1 with Data_in=10 -> Stop=1 5 edges after capture; N_out=4, Rem_out=0, Exact=1.
REQ-035 Scenario: Data_in=45 -> N_out=9, Rem_out=0, Exact=1; Data_in=78 -> N_out=12, Rem_out=0, Exact=1.
REQ-036 Scenario: Data_in=20 -> N_out=5, Rem_out=5, Exact=0; Data_in=0 -> N_out=0, Rem_out=0, Exact=1, Stop 1 edge after capture.
REQ-037 Scenario: Data_in=255 -> N_out=22, Rem_out=2, Exact=0, Stop 23 edges after capture.
REQ-038 Scenario: start Data_in=36, then pulse Reset at the 3rd SUB edge -> all outputs 0 at once, FSM in IDLE; restart with Data_in=28 -> N_out=7, Rem_out=0, Exact=1.
REQ-039 Scenario: in DONE, change Data_in while Start=1 -> outputs unchanged; drop Start -> Stop=0 next edge; raise Start with Data_in=6 -> N_out=3, Rem_out=0, Exact=1.
